// File: rtl/video_acc_cmd_issuer.sv
// video_acc_cmd_issuer
//   NASTI-Lite initiator feeding the accelerator command MMIO window. Each
//   64-bit DataMoverCommand accepted on cmd_* is written as two 32-bit words
//   (low at +0/+8, then high at +4/+12) to the source or destination queue.
//   Queue credit is tracked locally and refreshed by polling the occupancy
//   register of the queue (+0 src, +8 dest) whenever the credit runs out.
//
// Ports
//   aclk, aresetn              clock, async active-low reset
//   cmd_valid/cmd_ready        command handshake
//   cmd_dest                   0 = source queue, 1 = destination queue
//   cmd_data[63:0]             packed command, bit 0 = LSB of low word
//   busy                       FSM not idle
//   err, err_resp[1:0]         sticky error flag and first bad response code
//   m_nasti_aw_*/w_*/b_*       write channels (lite subset, one beat)
//   m_nasti_ar_*/r_*           read channels (lite subset, one beat)
//   stat_issued, stat_polls    only when VACC_ISSUE_STATS_EN is defined
//
// Build option
//   VACC_ISSUE_STATS_EN        adds the stat_issued/stat_polls counters

module video_acc_cmd_issuer #(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int unsigned BUF_DEPTH = 7,
  parameter int unsigned POLL_GAP  = 16
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_dest,
  input  logic [63:0] cmd_data,
  output logic        busy,
  output logic        err,
  output logic [1:0]  err_resp,
`ifdef VACC_ISSUE_STATS_EN
  output logic [31:0] stat_issued,
  output logic [31:0] stat_polls,
`endif
  output logic        m_nasti_aw_valid,
  input  logic        m_nasti_aw_ready,
  output logic [63:0] m_nasti_aw_addr,
  output logic [7:0]  m_nasti_aw_len,
  output logic [2:0]  m_nasti_aw_size,
  output logic [2:0]  m_nasti_aw_prot,
  output logic        m_nasti_w_valid,
  input  logic        m_nasti_w_ready,
  output logic [31:0] m_nasti_w_data,
  output logic [3:0]  m_nasti_w_strb,
  output logic        m_nasti_w_last,
  input  logic        m_nasti_b_valid,
  output logic        m_nasti_b_ready,
  input  logic [1:0]  m_nasti_b_resp,
  output logic        m_nasti_ar_valid,
  input  logic        m_nasti_ar_ready,
  output logic [63:0] m_nasti_ar_addr,
  output logic [7:0]  m_nasti_ar_len,
  output logic [2:0]  m_nasti_ar_size,
  output logic [2:0]  m_nasti_ar_prot,
  input  logic        m_nasti_r_valid,
  output logic        m_nasti_r_ready,
  input  logic [31:0] m_nasti_r_data,
  input  logic [1:0]  m_nasti_r_resp
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_POLL_A = 4'd1;
  localparam logic [3:0] S_POLL_R = 4'd2;
  localparam logic [3:0] S_GAP    = 4'd3;
  localparam logic [3:0] S_WLO_A  = 4'd4;
  localparam logic [3:0] S_WLO_B  = 4'd5;
  localparam logic [3:0] S_WHI_A  = 4'd6;
  localparam logic [3:0] S_WHI_B  = 4'd7;
  localparam logic [3:0] S_ERROR  = 4'd8;

  localparam int unsigned OCC_W = BUF_DEPTH + 1;
  localparam logic [OCC_W-1:0] CAP = {1'b1, {BUF_DEPTH{1'b0}}};
  localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

  logic [3:0]       state_q, state_d;
  logic             q_q, q_d;
  logic [63:0]      cmd_q, cmd_d;
  logic [OCC_W-1:0] free_src_q, free_src_d;
  logic [OCC_W-1:0] free_dst_q, free_dst_d;
  logic             aw_done_q, aw_done_d;
  logic             w_done_q, w_done_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             err_q, err_d;
  logic [1:0]       err_resp_q, err_resp_d;

  logic [OCC_W-1:0] free_req, free_cur, occ, poll_free, free_val;
  logic             free_wr, wr_phase_a, hi_half, aw_done_n, w_done_n;
  logic             unused_rdata;

  assign free_req  = cmd_dest ? free_dst_q : free_src_q;
  assign free_cur  = q_q ? free_dst_q : free_src_q;
  // A stale-high occupancy only lowers credit; anything at or above capacity is "full".
  assign occ       = m_nasti_r_data[BUF_DEPTH:0];
  assign poll_free = (occ >= CAP) ? '0 : CAP - occ;
  assign unused_rdata = ^m_nasti_r_data[31:BUF_DEPTH+1];

  assign wr_phase_a = (state_q == S_WLO_A) || (state_q == S_WHI_A);
  assign hi_half    = (state_q == S_WHI_A);
  assign aw_done_n  = aw_done_q | (m_nasti_aw_valid & m_nasti_aw_ready);
  assign w_done_n   = w_done_q  | (m_nasti_w_valid  & m_nasti_w_ready);

  assign cmd_ready = (state_q == S_IDLE) && (free_req != '0);
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;
  assign err_resp  = err_resp_q;

  assign m_nasti_aw_valid = wr_phase_a && !aw_done_q;
  assign m_nasti_aw_addr  = BASE_ADDR + {60'b0, q_q, hi_half, 2'b00};
  assign m_nasti_aw_len   = '0;
  assign m_nasti_aw_size  = 3'b010;
  assign m_nasti_aw_prot  = '0;
  assign m_nasti_w_valid  = wr_phase_a && !w_done_q;
  assign m_nasti_w_data   = hi_half ? cmd_q[63:32] : cmd_q[31:0];
  assign m_nasti_w_strb   = '1;
  assign m_nasti_w_last   = 1'b1;
  assign m_nasti_b_ready  = (state_q == S_WLO_B) || (state_q == S_WHI_B);
  assign m_nasti_ar_valid = (state_q == S_POLL_A);
  assign m_nasti_ar_addr  = BASE_ADDR + {60'b0, q_q, 3'b000};
  assign m_nasti_ar_len   = '0;
  assign m_nasti_ar_size  = 3'b010;
  assign m_nasti_ar_prot  = '0;
  assign m_nasti_r_ready  = (state_q == S_POLL_R);

  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    cmd_d      = cmd_q;
    free_src_d = free_src_q;
    free_dst_d = free_dst_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    gap_d      = gap_q;
    err_d      = err_q;
    err_resp_d = err_resp_q;
    free_wr    = 1'b0;
    free_val   = free_cur;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          q_d = cmd_dest;
          if (free_req != '0) begin
            cmd_d   = cmd_data;
            state_d = S_WLO_A;
          end else begin
            state_d = S_POLL_A;
          end
        end
      end
      S_POLL_A: if (m_nasti_ar_ready) state_d = S_POLL_R;
      S_POLL_R: begin
        if (m_nasti_r_valid) begin
          if (m_nasti_r_resp != 2'b00) begin
            state_d    = S_ERROR;
            err_d      = 1'b1;
            err_resp_d = m_nasti_r_resp;
          end else begin
            free_wr  = 1'b1;
            free_val = poll_free;
            gap_d    = '0;
            state_d  = (poll_free != '0) ? S_IDLE : S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_POLL_A;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      // AW and W complete independently; move on once both have handshaken.
      S_WLO_A, S_WHI_A: begin
        if (aw_done_n && w_done_n) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = hi_half ? S_WHI_B : S_WLO_B;
        end else begin
          aw_done_d = aw_done_n;
          w_done_d  = w_done_n;
        end
      end
      S_WLO_B, S_WHI_B: begin
        if (m_nasti_b_valid) begin
          if (m_nasti_b_resp != 2'b00) begin
            state_d    = S_ERROR;
            err_d      = 1'b1;
            err_resp_d = m_nasti_b_resp;
          end else if (state_q == S_WLO_B) begin
            state_d = S_WHI_A;
          end else begin
            free_wr  = 1'b1;
            free_val = (free_cur != '0) ? free_cur - 1'b1 : '0;
            state_d  = S_IDLE;
          end
        end
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase

    if (free_wr) begin
      if (q_q) free_dst_d = free_val;
      else     free_src_d = free_val;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      q_q        <= 1'b0;
      cmd_q      <= '0;
      free_src_q <= '0;
      free_dst_q <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      gap_q      <= '0;
      err_q      <= 1'b0;
      err_resp_q <= '0;
    end else begin
      state_q    <= state_d;
      q_q        <= q_d;
      cmd_q      <= cmd_d;
      free_src_q <= free_src_d;
      free_dst_q <= free_dst_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      gap_q      <= gap_d;
      err_q      <= err_d;
      err_resp_q <= err_resp_d;
    end
  end

`ifdef VACC_ISSUE_STATS_EN
  logic [31:0] issued_q, polls_q;
  logic        issue_ok;

  assign issue_ok = (state_q == S_WHI_B) && m_nasti_b_valid && (m_nasti_b_resp == 2'b00);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      issued_q <= '0;
      polls_q  <= '0;
    end else begin
      if (issue_ok) issued_q <= issued_q + 32'd1;
      if (m_nasti_ar_valid && m_nasti_ar_ready) polls_q <= polls_q + 32'd1;
    end
  end

  assign stat_issued = issued_q;
  assign stat_polls  = polls_q;
`endif

endmodule

// File: tb/tb_video_acc_cmd_issuer.sv
// Testbench for video_acc_cmd_issuer: NASTI-Lite responder with configurable
// delays and occupancy, scoreboard of expected MMIO writes, credit model.
module tb_video_acc_cmd_issuer;

  localparam logic [63:0] BASE = 64'h0000_0001_2000_0000;
  localparam int GAP = 16;

  logic        aclk, aresetn;
  logic        cmd_valid, cmd_ready, cmd_dest;
  logic [63:0] cmd_data;
  logic        busy, err;
  logic [1:0]  err_resp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [63:0] awaddr, araddr;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, awprot, arsize, arprot;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic [1:0]  bresp, rresp;
`ifdef VACC_ISSUE_STATS_EN
  logic [31:0] stat_issued, stat_polls;
`endif

  video_acc_cmd_issuer #(.BASE_ADDR(BASE), .BUF_DEPTH(7), .POLL_GAP(GAP)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dest(cmd_dest), .cmd_data(cmd_data),
    .busy(busy), .err(err), .err_resp(err_resp),
`ifdef VACC_ISSUE_STATS_EN
    .stat_issued(stat_issued), .stat_polls(stat_polls),
`endif
    .m_nasti_aw_valid(awvalid), .m_nasti_aw_ready(awready), .m_nasti_aw_addr(awaddr),
    .m_nasti_aw_len(awlen), .m_nasti_aw_size(awsize), .m_nasti_aw_prot(awprot),
    .m_nasti_w_valid(wvalid), .m_nasti_w_ready(wready), .m_nasti_w_data(wdata),
    .m_nasti_w_strb(wstrb), .m_nasti_w_last(wlast),
    .m_nasti_b_valid(bvalid), .m_nasti_b_ready(bready), .m_nasti_b_resp(bresp),
    .m_nasti_ar_valid(arvalid), .m_nasti_ar_ready(arready), .m_nasti_ar_addr(araddr),
    .m_nasti_ar_len(arlen), .m_nasti_ar_size(arsize), .m_nasti_ar_prot(arprot),
    .m_nasti_r_valid(rvalid), .m_nasti_r_ready(rready), .m_nasti_r_data(rdata),
    .m_nasti_r_resp(rresp)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // Expected MMIO writes, in issue order.
  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] data;
    logic        dest;
    logic        hi;
  } wr_t;
  wr_t exp_q[$];

  // Responder knobs and bookkeeping
  int   aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0] b_err_next = 2'b00;
  int   occ_script[$];
  int   occ_default = 0;
  bit   rand_occ = 0;
  bit   cur_dest = 0;
  int   credit[2];
  int   ar_count = 0, wr_count = 0, polls_sr = 0, issued_sr = 0;
  int   ar_cyc_last = 0, ar_cyc_prev = 0;

  initial begin : responder
    int aw_wait, w_wait, b_wait, ar_wait, r_wait, occ_v;
    bit aw_got, w_got, b_pend, r_pend, b_hs, r_hs, b_for_hi;
    logic [63:0] aw_addr_c;
    logic [7:0]  aw_len_c;
    logic [2:0]  aw_size_c, aw_prot_c;
    logic [31:0] w_data_c;
    logic [3:0]  w_strb_c;
    logic        w_last_c;
    wr_t e;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; b_hs = 0; r_hs = 0; b_for_hi = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0; b_hs = 0; r_hs = 0;
        continue;
      end
      // Readies are one-cycle pulses raised only against a visible valid.
      awready = 0; wready = 0; arready = 0;
      if (b_hs) begin
        bvalid = 0;
        if (bresp == 2'b00 && b_for_hi) issued_sr++;
      end
      if (r_hs) rvalid = 0;
      if (aw_got) chk("no_dup_aw", awvalid, 0);
      if (w_got)  chk("single_w_beat", wvalid, 0);
      // Read data for an accepted poll
      if (r_pend) begin
        if (r_wait >= r_delay) begin
          if (occ_script.size() > 0) occ_v = occ_script.pop_front();
          else if (rand_occ) occ_v = ($urandom_range(0, 3) == 0) ? 128 : int'($urandom_range(100, 127));
          else occ_v = occ_default;
          rdata = occ_v; rresp = 2'b00; rvalid = 1; r_pend = 0;
          credit[cur_dest] = (occ_v >= 128) ? 0 : 128 - occ_v;
        end else r_wait++;
      end
      if (awvalid && !aw_got) begin
        if (aw_wait >= aw_delay) begin
          awready = 1; aw_got = 1; aw_wait = 0;
          aw_addr_c = awaddr; aw_len_c = awlen; aw_size_c = awsize; aw_prot_c = awprot;
        end else aw_wait++;
      end
      if (wvalid && !w_got) begin
        if (w_wait >= w_delay) begin
          wready = 1; w_got = 1; w_wait = 0;
          w_data_c = wdata; w_strb_c = wstrb; w_last_c = wlast;
        end else w_wait++;
      end
      if (arvalid && !r_pend && !rvalid) begin
        if (ar_wait >= ar_delay) begin
          arready = 1; ar_wait = 0; r_pend = 1; r_wait = 0;
          ar_count++; polls_sr++;
          ar_cyc_prev = ar_cyc_last; ar_cyc_last = cyc;
          chk("ar_addr", araddr, BASE + (cur_dest ? 64'd8 : 64'd0));
          chk("ar_size", {61'b0, arsize}, 64'd2);
          chk("ar_len", {56'b0, arlen}, 64'd0);
        end else ar_wait++;
      end
      // Write monitor: compare each completed AW+W pair against the scoreboard.
      if (aw_got && w_got) begin
        aw_got = 0; w_got = 0; wr_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", aw_addr_c, 64'hFFFF_FFFF_FFFF_FFFF);
          b_for_hi = 0;
        end else begin
          e = exp_q.pop_front();
          chk("aw_addr", aw_addr_c, e.addr);
          chk("w_data", {32'b0, w_data_c}, {32'b0, e.data});
          chk("w_strb", {60'b0, w_strb_c}, 64'hF);
          chk("w_last", {63'b0, w_last_c}, 64'd1);
          chk("aw_size", {61'b0, aw_size_c}, 64'd2);
          chk("aw_len_prot", {53'b0, aw_len_c, aw_prot_c}, 64'd0);
          b_for_hi = e.hi;
          if (e.hi) begin
            chk("credit_available", {63'b0, credit[e.dest] > 0}, 64'd1);
            if (credit[e.dest] > 0) credit[e.dest]--;
          end
        end
        b_pend = 1; b_wait = 0;
      end
      // B may rise on the same edge as the last AW/W handshake.
      if (b_pend) begin
        if (b_wait >= b_delay) begin
          bvalid = 1; bresp = b_err_next; b_err_next = 2'b00; b_pend = 0;
        end else b_wait++;
      end
      b_hs = bvalid && bready;
      r_hs = rvalid && rready;
    end
  end

  task automatic apply_reset();
    @(negedge aclk);
    aresetn = 0;
    cmd_valid = 0;
    exp_q.delete();
    occ_script.delete();
    credit[0] = 0; credit[1] = 0;
    polls_sr = 0; issued_sr = 0;
    repeat (2) @(negedge aclk);
    aresetn = 1;
    @(negedge aclk);
  endtask

  // Offer one command; push its expected write pair when it is accepted.
  task automatic send_cmd(input logic d, input logic [63:0] data);
    bit ok = 0;
    cur_dest = d;
    cmd_dest = d; cmd_data = data; cmd_valid = 1;
    for (int n = 0; n < 4000 && !ok; n++) begin
      #1;
      if (cmd_ready) begin
        exp_q.push_back('{addr: BASE + (d ? 64'd8 : 64'd0), data: data[31:0], dest: d, hi: 1'b0});
        exp_q.push_back('{addr: BASE + (d ? 64'd12 : 64'd4), data: data[63:32], dest: d, hi: 1'b1});
        ok = 1;
      end
      @(negedge aclk);
    end
    cmd_valid = 0;
    if (!ok) timeout_fail("cmd_accept");
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 4000; n++) begin
      @(negedge aclk);
      if (exp_q.size() == 0 && !busy && !bvalid) return;
    end
    timeout_fail("wait_idle");
  endtask

  task automatic set_delays(input int a, input int w, input int b, input int ar, input int r);
    aw_delay = a; w_delay = w; b_delay = b; ar_delay = ar; r_delay = r;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int ar0, wr0;
    logic [63:0] d64;
    aresetn = 1; cmd_valid = 0; cmd_dest = 0; cmd_data = '0;
    credit[0] = 0; credit[1] = 0;
    #2 aresetn = 0;
    #1;
    chk("rst_cmd_ready", {63'b0, cmd_ready}, 0);
    chk("rst_busy", {63'b0, busy}, 0);
    chk("rst_err", {61'b0, err, err_resp}, 0);
    chk("rst_valids", {60'b0, awvalid, wvalid, arvalid, 1'b0}, 0);
    chk("rst_readies", {62'b0, bready, rready}, 0);
    repeat (2) @(negedge aclk);
    aresetn = 1;
    @(negedge aclk);

    // Basic source command: one poll (occupancy 0), then low/high writes.
    set_delays(0, 0, 0, 0, 0);
    occ_default = 0;
    ar0 = ar_count;
    send_cmd(1'b0, 64'h0000_0040_0000_1001);
    wait_idle();
    chk("basic_polls", ar_count - ar0, 1);
    cmd_dest = 0;
    #1 chk("basic_ready_after", {63'b0, cmd_ready}, 1);
    @(negedge aclk);

    // Queue full: 128 -> GAP and re-poll, 127 -> exactly one credit.
    apply_reset();
    occ_script.push_back(128);
    occ_script.push_back(127);
    ar0 = ar_count;
    send_cmd(1'b0, {$urandom, $urandom});
    wait_idle();
    chk("full_polls", ar_count - ar0, 2);
    chk("full_gap_cycles", ar_cyc_last - ar_cyc_prev, GAP + 2);
    send_cmd(1'b0, {$urandom, $urandom});
    wait_idle();
    chk("full_repoll_after_credit", ar_count - ar0, 3);

    // AW and W readiness skewed both ways.
    set_delays(0, 3, 0, 0, 0);
    send_cmd(1'b1, {$urandom, $urandom});
    wait_idle();
    set_delays(3, 0, 1, 0, 0);
    send_cmd(1'b0, {$urandom, $urandom});
    wait_idle();

    // SLVERR on the low half: no high write, terminal error.
    apply_reset();
    set_delays(0, 0, 0, 0, 0);
    b_err_next = 2'b10;
    send_cmd(1'b1, {$urandom, $urandom});
    wr0 = wr_count;
    for (int n = 0; n < 200 && !err; n++) @(negedge aclk);
    repeat (20) @(negedge aclk);
    chk("err_flag", {63'b0, err}, 1);
    chk("err_resp", {62'b0, err_resp}, 2);
    chk("err_no_high_write", wr_count - wr0, 0);
    chk("err_busy", {63'b0, busy}, 1);
    cmd_valid = 1; cmd_dest = 1;
    #1 chk("err_cmd_ready", {63'b0, cmd_ready}, 0);
    apply_reset();
    chk("err_cleared", {61'b0, err, err_resp}, 0);

    // Alternate queues back to back.
    for (int i = 0; i < 6; i++) begin
      d64 = {$urandom, $urandom};
      send_cmd(i[0], d64);
    end
    wait_idle();

    // Reset while the high-half AW is pending.
    apply_reset();
    set_delays(6, 0, 0, 0, 0);
    send_cmd(1'b0, {$urandom, $urandom});
    begin
      bit seen = 0;
      for (int n = 0; n < 200 && !seen; n++) begin
        if (awvalid && awaddr == BASE + 64'd4) seen = 1;
        else @(negedge aclk);
      end
      if (!seen) timeout_fail("reach_whi_a");
    end
    #2 aresetn = 0;
    exp_q.delete();
    #1;
    chk("midrst_valids", {61'b0, awvalid, wvalid, arvalid}, 0);
    chk("midrst_idle", {62'b0, busy, bready}, 0);
    credit[0] = 0; credit[1] = 0;
    polls_sr = 0; issued_sr = 0;
    repeat (2) @(negedge aclk);
    aresetn = 1;
    @(negedge aclk);
    set_delays(0, 0, 0, 0, 0);
    ar0 = ar_count;
    send_cmd(1'b0, {$urandom, $urandom});
    wait_idle();
    chk("midrst_credit_cleared", ar_count - ar0, 1);

    // Randomised traffic with random delays and occupancy.
    rand_occ = 1;
    for (int i = 0; i < 40; i++) begin
      set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 2), $urandom_range(0, 2));
      send_cmd(1'($urandom_range(0, 1)), {$urandom, $urandom});
    end
    wait_idle();
    chk("scoreboard_empty", exp_q.size(), 0);

`ifdef VACC_ISSUE_STATS_EN
    chk("stat_polls", {32'b0, stat_polls}, polls_sr);
    chk("stat_issued", {32'b0, stat_issued}, issued_sr);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
